// File: rtl/core_bus_pkg.sv
// Shared encodings for the core-side bus bridges: FSM state codes, default address width, error data word.
// No logic; constants only.
// Imported by core_wishbone_master and its helpers.
package core_bus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int          WB_ADDRESS_WIDTH = 28;
    localparam logic [31:0] WB_ERROR_DATA    = 32'hFFFF_FFFF;

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags the LIMIT-th one.
// Latency: expired is combinational on the count, high during the LIMIT-th enabled cycle.
// Backpressure: none; clear has priority over enable.
module wb_timeout_counter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // count holds (cycles already spent in BUS), so the LIMIT-th cycle sees LIMIT-1
    assign expired = enable && (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/core_wishbone_master.sv
// Bridges the memory controller's WB request port onto Wishbone classic single transfers (optional WB_MASTER_TIMEOUT_EN watchdog).
// Latency: request cycle 0, cyc/stb from cycle 1 until ack/err, busy low the cycle after; minimum 3 cycles.
// Backpressure: wbBusy held high from request until the DONE cycle; one transfer in flight.
module core_wishbone_master
    import core_bus_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = WB_ADDRESS_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] wbAddress,
    input  logic [3:0]               wbByteSelect,
    input  logic                     wbWriteEnable,
    input  logic                     wbReadEnable,
    input  logic [31:0]              wbDataWrite,
    output logic [31:0]              wbDataRead,
    output logic                     wbBusy,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [3:0]               wb_sel_o,
    output logic [ADDRESS_WIDTH-1:0] wb_adr_o,
    output logic [31:0]              wb_data_o,
    input  logic [31:0]              wb_data_i,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       request;
    logic       in_bus;
    logic       timeout_expired;
    logic       abort;

    assign request = wbReadEnable | wbWriteEnable;
    assign in_bus  = (state == ST_BUS);

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    wb_timeout_counter #(
        .WIDTH (CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_bus),
        .enable  (in_bus),
        .expired (timeout_expired)
    );
`else
    // Watchdog not built: BUS waits for ack/err indefinitely for any sane TIMEOUT_CYCLES.
    assign timeout_expired = (TIMEOUT_CYCLES < 0);
`endif

    // A genuine ack in the expiry cycle still completes normally.
    assign abort = wb_err_i | (timeout_expired & ~wb_ack_i);

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE: state_next = request ? ST_BUS : ST_IDLE;
            ST_BUS:  state_next = (wb_ack_i | abort) ? ST_DONE : ST_BUS;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request is captured once on acceptance; core-side changes during BUS are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_adr_o  <= '0;
            wb_data_o <= '0;
        end else if (state == ST_IDLE && request) begin
            wb_we_o   <= wbWriteEnable;
            wb_sel_o  <= wbByteSelect;
            wb_adr_o  <= wbAddress;
            wb_data_o <= wbDataWrite;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbDataRead <= '0;
        end else if (in_bus) begin
            if (abort) begin
                wbDataRead <= WB_ERROR_DATA;
            end else if (wb_ack_i && !wb_we_o) begin
                wbDataRead <= wb_data_i;
            end
        end
    end

    assign wb_cyc_o = in_bus;
    assign wb_stb_o = in_bus;
    assign wbBusy   = in_bus | ((state == ST_IDLE) & request);

endmodule

// File: tb/tb_core_wishbone_master.sv
// Directed bench for core_wishbone_master; completion data checked against a queue of expected results.
module tb_core_wishbone_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] wbAddress = '0;
    logic [3:0]  wbByteSelect = '0;
    logic        wbWriteEnable = 1'b0;
    logic        wbReadEnable = 1'b0;
    logic [31:0] wbDataWrite = '0;
    logic [31:0] wbDataRead;
    logic        wbBusy;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [27:0] wb_adr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_data;

    core_wishbone_master #(
        .ADDRESS_WIDTH  (28),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wbAddress     (wbAddress),
        .wbByteSelect  (wbByteSelect),
        .wbWriteEnable (wbWriteEnable),
        .wbReadEnable  (wbReadEnable),
        .wbDataWrite   (wbDataWrite),
        .wbDataRead    (wbDataRead),
        .wbBusy        (wbBusy),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_sel_o      (wb_sel_o),
        .wb_adr_o      (wb_adr_o),
        .wb_data_o     (wb_data_o),
        .wb_data_i     (wb_data_i),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [27:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        wbReadEnable  = rd;
        wbWriteEnable = wr;
        wbAddress     = a;
        wbByteSelect  = s;
        wbDataWrite   = d;
    endtask

    task automatic drop_request();
        issue(1'b0, 1'b0, 28'h0, 4'h0, 32'h0);
    endtask

    task automatic check_done(input string tag);
        exp_data = exp_q.pop_front();
        check({tag, "_cyc_done"}, {31'b0, wb_cyc_o}, 32'd0);
        check({tag, "_busy_done"}, {31'b0, wbBusy}, 32'd0);
        check({tag, "_rdata"}, wbDataRead, exp_data);
    endtask

    initial begin
        int cyc_count;
        bit finished;

        // Reset state
        #3;
        check("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        check("rst_stb", {31'b0, wb_stb_o}, 32'd0);
        check("rst_we", {31'b0, wb_we_o}, 32'd0);
        check("rst_sel", {28'b0, wb_sel_o}, 32'd0);
        check("rst_adr", {4'b0, wb_adr_o}, 32'd0);
        check("rst_dout", wb_data_o, 32'd0);
        check("rst_rdata", wbDataRead, 32'd0);
        check("rst_busy", {31'b0, wbBusy}, 32'd0);
        #10 rst = 1'b0;
        step(); step();
        settle();
        check("idle_no_activity", {30'b0, wb_cyc_o, wbBusy}, 32'd0);

        // 1: read, ack on second BUS cycle
        step();
        issue(1'b1, 1'b0, 28'h000_0010, 4'hF, 32'h0);
        exp_q.push_back(32'hDEAD_BEEF);
        settle();
        check("t1_busy_req", {31'b0, wbBusy}, 32'd1);
        check("t1_cyc_req", {31'b0, wb_cyc_o}, 32'd0);
        step();
        drop_request();
        settle();
        check("t1_cyc_b1", {30'b0, wb_cyc_o, wb_stb_o}, 32'd3);
        check("t1_busy_b1", {31'b0, wbBusy}, 32'd1);
        check("t1_adr", {4'b0, wb_adr_o}, 32'h0000_0010);
        check("t1_we", {31'b0, wb_we_o}, 32'd0);
        step();
        wb_ack_i = 1'b1; wb_data_i = 32'hDEAD_BEEF;
        settle();
        check("t1_cyc_b2", {30'b0, wb_cyc_o, wb_stb_o}, 32'd3);
        step();
        wb_ack_i = 1'b0; wb_data_i = 32'h0;
        settle();
        check_done("t1");
        step();
        settle();
        check("t1_idle", {30'b0, wb_cyc_o, wbBusy}, 32'd0);
        check("t1_rdata_held", wbDataRead, 32'hDEAD_BEEF);

        // 2: write with core inputs changing mid-BUS
        step();
        issue(1'b0, 1'b1, 28'h0AB_CDE4, 4'b0110, 32'h1234_5678);
        exp_q.push_back(32'hDEAD_BEEF);
        step();
        issue(1'b1, 1'b0, 28'h555_5555, 4'hF, 32'hCAFE_F00D);
        settle();
        check("t2_adr_b1", {4'b0, wb_adr_o}, 32'h00AB_CDE4);
        check("t2_sel_b1", {28'b0, wb_sel_o}, 32'h6);
        check("t2_dout_b1", wb_data_o, 32'h1234_5678);
        check("t2_we_b1", {31'b0, wb_we_o}, 32'd1);
        step();
        issue(1'b0, 1'b0, 28'h0FF_FFFF, 4'h1, 32'h0BAD_0BAD);
        wb_ack_i = 1'b1; wb_data_i = 32'h7777_7777;
        settle();
        check("t2_adr_b2", {4'b0, wb_adr_o}, 32'h00AB_CDE4);
        check("t2_dout_b2", wb_data_o, 32'h1234_5678);
        check("t2_we_b2", {31'b0, wb_we_o}, 32'd1);
        step();
        wb_ack_i = 1'b0; wb_data_i = 32'h0;
        drop_request();
        settle();
        check_done("t2");
        step();

        // 3: both enables set -> write wins
        step();
        issue(1'b1, 1'b1, 28'h000_0020, 4'hF, 32'hAAAA_5555);
        exp_q.push_back(32'hDEAD_BEEF);
        step();
        drop_request();
        settle();
        check("t3_we", {31'b0, wb_we_o}, 32'd1);
        check("t3_dout", wb_data_o, 32'hAAAA_5555);
        wb_ack_i = 1'b1; wb_data_i = 32'h1111_1111;
        step();
        wb_ack_i = 1'b0; wb_data_i = 32'h0;
        settle();
        check_done("t3");
        step();

        // 4: error response on a read
        step();
        issue(1'b1, 1'b0, 28'h000_0030, 4'hF, 32'h0);
        exp_q.push_back(32'hFFFF_FFFF);
        step();
        drop_request();
        wb_err_i = 1'b1; wb_data_i = 32'h2222_2222;
        settle();
        check("t4_cyc_b1", {31'b0, wb_cyc_o}, 32'd1);
        step();
        wb_err_i = 1'b0; wb_data_i = 32'h0;
        settle();
        check_done("t4");
        step();

        // 5: reset in the middle of BUS
        step();
        issue(1'b1, 1'b0, 28'h000_0038, 4'hF, 32'h0);
        step();
        drop_request();
        settle();
        check("t5_cyc_before_rst", {31'b0, wb_cyc_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_cyc_in_rst", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("t5_busy_in_rst", {31'b0, wbBusy}, 32'd0);
        #1 rst = 1'b0;
        step();
        wb_ack_i = 1'b1; wb_data_i = 32'h3333_3333;
        settle();
        check("t5_late_ack_cyc", {30'b0, wb_cyc_o, wbBusy}, 32'd0);
        step();
        wb_ack_i = 1'b0; wb_data_i = 32'h0;
        settle();
        check("t5_late_ack_rdata", wbDataRead, 32'd0);
        issue(1'b1, 1'b0, 28'h000_0040, 4'hF, 32'h0);
        exp_q.push_back(32'h4444_4444);
        step();
        drop_request();
        wb_ack_i = 1'b1; wb_data_i = 32'h4444_4444;
        settle();
        check("t5_after_rst_adr", {4'b0, wb_adr_o}, 32'h0000_0040);
        step();
        wb_ack_i = 1'b0; wb_data_i = 32'h0;
        settle();
        check_done("t5");
        step();

        // 6: silent slave
        step();
        issue(1'b1, 1'b0, 28'h000_0050, 4'hF, 32'h0);
        step();
        drop_request();
        settle();
        cyc_count = 0;
        finished = 1'b0;
        for (int i = 0; i < 200 && !finished; i++) begin
            if (wb_cyc_o) cyc_count++;
            else finished = 1'b1;
            if (!finished) step();
`ifndef WB_MASTER_TIMEOUT_EN
            if (cyc_count == 120) finished = 1'b1;
`endif
        end
`ifdef WB_MASTER_TIMEOUT_EN
        exp_q.push_back(32'hFFFF_FFFF);
        check("t6_timeout_cycles", cyc_count, 32'd4);
        check_done("t6");
`else
        check("t6_no_timeout_cycles", cyc_count, 32'd120);
        check("t6_still_busy", {30'b0, wb_cyc_o, wbBusy}, 32'd3);
        exp_q.push_back(32'h6666_6666);
        wb_ack_i = 1'b1; wb_data_i = 32'h6666_6666;
        step();
        wb_ack_i = 1'b0; wb_data_i = 32'h0;
        settle();
        check_done("t6");
`endif
        check("sb_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
